// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS register-index and RegDest selector constants
//
// Purpose : constants shared by the register bank, the control unit and benches.
//   REG_ZERO/REG_SP/REG_FP/REG_RA : architectural register indices
//   SP_RESET                      : reset value of the stack pointer ($29)
//   regdest_e                     : RegDest mux selector encodings
package mips_pkg;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [4:0]  REG_FP   = 5'd30;
  localparam logic [4:0]  REG_RA   = 5'd31;

  localparam logic [31:0] SP_RESET = 32'd227;

  typedef enum logic [2:0] {
    REGDST_RT     = 3'd0,
    REGDST_OFFSET = 3'd1,
    REGDST_SP     = 3'd2,
    REGDST_FP     = 3'd3,
    REGDST_RA     = 3'd4
  } regdest_e;

endpackage

// File: rtl/registrador.sv
// rtl/registrador.sv - W-bit load-enable register with sync active-low reset
//
// Purpose : storage element used for each register-bank entry and for A/B.
// Ports   :
//   i_clk    in  1  rising-edge clock
//   i_resetn in  1  synchronous active-low reset (loads RST_VAL, dominates i_en)
//   i_en     in  1  load enable
//   i_d      in  W  data in
//   o_q      out W  registered data
module registrador #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_resetn,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - 32x32 MIPS register bank with A/B operand registers
//
// Purpose : general-purpose register file (one write port, two combinational
//           read ports) plus the multicycle datapath's A/B holding registers.
//           $0 reads as zero and ignores writes; $29 resets to SP_RESET.
// Build option : REG_BANK_BYPASS_EN - a same-cycle write to a read index is
//           forwarded to read_data* (and so into A/B on a same-cycle load_ab).
// Ports   :
//   clk         in  1       rising-edge clock
//   reset       in  1       synchronous active-low reset
//   reg_write   in  1       write enable
//   write_reg   in  AW      destination index (RegDest mux output)
//   write_data  in  DATA_W  write-back data
//   read_reg1   in  AW      rs index
//   read_reg2   in  AW      rt index
//   load_ab     in  1       capture read_data1/2 into A_out/B_out
//   read_data1  out DATA_W  combinational read of read_reg1
//   read_data2  out DATA_W  combinational read of read_reg2
//   A_out       out DATA_W  registered rs operand
//   B_out       out DATA_W  registered rt operand
module banco_registradores
  import mips_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 N_REGS   = 32,
  parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(mips_pkg::SP_RESET),
  localparam int                AW       = $clog2(N_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [AW-1:0]     write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [AW-1:0]     read_reg1,
  input  logic [AW-1:0]     read_reg2,
  input  logic              load_ab,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] A_out,
  output logic [DATA_W-1:0] B_out
);

  logic [DATA_W-1:0] w_regs [N_REGS];

  // $0 has no storage: it is a constant zero, so writes to it vanish.
  assign w_regs[0] = '0;

  for (genvar i = 1; i < N_REGS; i++) begin : g_reg
    registrador #(
      .W      (DATA_W),
      .RST_VAL((i == int'(REG_SP)) ? SP_RESET : '0)
    ) u_reg (
      .i_clk   (clk),
      .i_resetn(reset),
      .i_en    (reg_write && (write_reg == AW'(i))),
      .i_d     (write_data),
      .o_q     (w_regs[i])
    );
  end

`ifdef REG_BANK_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // Forwarding excludes $0 so the hardwired zero is never overridden.
  assign w_fwd1 = reg_write && (write_reg != '0) && (write_reg == read_reg1);
  assign w_fwd2 = reg_write && (write_reg != '0) && (write_reg == read_reg2);

  always_comb begin
    read_data1 = w_regs[read_reg1];
    read_data2 = w_regs[read_reg2];
    if (w_fwd1) read_data1 = write_data;
    if (w_fwd2) read_data2 = write_data;
  end
`else
  assign read_data1 = w_regs[read_reg1];
  assign read_data2 = w_regs[read_reg2];
`endif

  registrador #(
    .W      (DATA_W),
    .RST_VAL('0)
  ) u_reg_a (
    .i_clk   (clk),
    .i_resetn(reset),
    .i_en    (load_ab),
    .i_d     (read_data1),
    .o_q     (A_out)
  );

  registrador #(
    .W      (DATA_W),
    .RST_VAL('0)
  ) u_reg_b (
    .i_clk   (clk),
    .i_resetn(reset),
    .i_en    (load_ab),
    .i_d     (read_data2),
    .o_q     (B_out)
  );

endmodule
